// File: rtl/s27_scan_pkg.sv
// Shared types and constants for the s27 scan state register.
package s27_scan_pkg;

  localparam int unsigned NUM_FF_DEF = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  localparam int unsigned CNT_W_DEF = clog2(NUM_FF_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/s27_scan_state_reg_if.sv
// Core-facing state bus plus scan and test-request handshake for the s27 state register.
interface s27_scan_state_reg_if #(
  parameter int unsigned NUM_FF = 3
);
  logic [NUM_FF-1:0] d_in;
  logic [NUM_FF-1:0] q_out;
  logic              func_en;
  logic              scan_en;
  logic              scan_in;
  logic              scan_out;
  logic              test_req_valid;
  logic              test_req_ready;
  logic [NUM_FF-1:0] test_pat;
  logic              test_resp_valid;
  logic [NUM_FF-1:0] test_resp;
  logic              busy;

  modport master (
    output d_in, func_en, scan_en, scan_in, test_req_valid, test_pat,
    input  q_out, scan_out, test_req_ready, test_resp_valid, test_resp, busy
  );

  modport slave (
    input  d_in, func_en, scan_en, scan_in, test_req_valid, test_pat,
    output q_out, scan_out, test_req_ready, test_resp_valid, test_resp, busy
  );
endinterface

// File: rtl/s27_scan_cell.sv
// One mux-D scan flop: shift input or functional input, loaded when enabled.
module s27_scan_cell (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  input  logic sin_i,
  input  logic sel_shift_i,
  input  logic en_i,
  input  logic rst_val_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= rst_val_i;
    end else if (en_i) begin
      q_q <= sel_shift_i ? sin_i : d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/s27_scan_state_reg.sv
// s27 state register with scan chain and a self-sequencing shift/capture/unload controller.
module s27_scan_state_reg
  import s27_scan_pkg::*;
#(
  parameter int unsigned           NUM_FF    = NUM_FF_DEF,
  parameter logic [NUM_FF-1:0]     RESET_VAL = '0
) (
  input  logic                blif_clk_net,
  input  logic                blif_reset_net,
  s27_scan_state_reg_if.slave bus
);

  localparam int unsigned CNT_W = clog2(NUM_FF) + 1;

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_FF-1:0] pat_sr_q, pat_sr_d;
  logic [NUM_FF-1:0] resp_sr_q, resp_sr_d;
  logic [NUM_FF-1:0] resp_hold_q, resp_hold_d;

  logic [NUM_FF-1:0] q;
  logic [NUM_FF-1:0] sin_vec;
  logic              cell_en;
  logic              cell_sel;
  logic              chain_sin;
  logic              accept;
  logic              last;

  assign accept  = bus.test_req_valid && (state_q == IDLE);
  assign last    = (cnt_q == CNT_W'(NUM_FF - 1));
  assign sin_vec = {chain_sin, q[NUM_FF-1:1]};

  for (genvar k = 0; k < NUM_FF; k++) begin : g_cell
    s27_scan_cell u_cell (
      .clk         (blif_clk_net),
      .rst         (blif_reset_net),
      .d_i         (bus.d_in[k]),
      .sin_i       (sin_vec[k]),
      .sel_shift_i (cell_sel),
      .en_i        (cell_en),
      .rst_val_i   (RESET_VAL[k]),
      .q_o         (q[k])
    );
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = SHIFT_IN;
      SHIFT_IN:  if (last) state_d = CAPTURE;
      CAPTURE:   state_d = SHIFT_OUT;
      SHIFT_OUT: if (last) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Flop controls and controller datapath; while the FSM is active the external enables are ignored.
  always_comb begin
    cell_en     = 1'b0;
    cell_sel    = 1'b0;
    chain_sin   = 1'b0;
    cnt_d       = cnt_q;
    pat_sr_d    = pat_sr_q;
    resp_sr_d   = resp_sr_q;
    resp_hold_d = resp_hold_q;
    case (state_q)
      IDLE: begin
        if (bus.scan_en) begin
          cell_en   = 1'b1;
          cell_sel  = 1'b1;
          chain_sin = bus.scan_in;
        end else if (bus.func_en) begin
          cell_en = 1'b1;
        end
        if (accept) begin
          pat_sr_d = bus.test_pat;
          cnt_d    = '0;
        end
      end
      SHIFT_IN: begin
        cell_en   = 1'b1;
        cell_sel  = 1'b1;
        chain_sin = pat_sr_q[0];
        pat_sr_d  = pat_sr_q >> 1;
        cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
      end
      CAPTURE: begin
        cell_en = 1'b1;
        cnt_d   = '0;
      end
      SHIFT_OUT: begin
        cell_en   = 1'b1;
        cell_sel  = 1'b1;
        resp_sr_d = {q[0], resp_sr_q[NUM_FF-1:1]};
        cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
      end
      DONE: begin
        resp_hold_d = resp_sr_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      cnt_q       <= '0;
      pat_sr_q    <= '0;
      resp_sr_q   <= '0;
      resp_hold_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pat_sr_q    <= pat_sr_d;
      resp_sr_q   <= resp_sr_d;
      resp_hold_q <= resp_hold_d;
    end
  end

  // Response is presented straight from the unload register during DONE, then held.
  assign bus.q_out           = q;
  assign bus.scan_out        = q[0];
  assign bus.test_req_ready  = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.test_resp_valid = (state_q == DONE);
  assign bus.test_resp       = resp_hold_d;

endmodule
